dbg_auth_unlock: RTL and testbench
==================================

Name: dbg_auth_unlock

Overview:
- Debug-authentication responder; sits between the DMI/JTAG debug transport and csr_regfile.
- Accepts a streamed multi-word password and compares it against a fused key in constant time.
- Produces the registered unlock grant that gates debug-mode and privilege escalation in csr_regfile.
- Enforces an attempt limit and timed lockout. A failed or aborted check never produces a grant.

Parameters:
- KEY_WORDS, 4, number of 32-bit password words per attempt (>=1).
- MAX_ATTEMPTS, 3, consecutive failures before lockout (>=1).
- LOCKOUT_CYCLES, 1024, clock cycles spent in lockout (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- key_i  in  KEY_WORDS*32  fused reference key; word 0 = bits [31:0]; static after reset
- req_valid_i  in  1  password word valid
- req_ready_o  out  1  unit accepts a password word
- req_data_i  in  32  password word, word 0 first
- abort_i  in  1  transport aborts current attempt
- resp_valid_o  out  1  attempt result valid
- resp_ready_i  in  1  transport accepts result
- resp_ok_o  out  1  result: 1 = password matched
- relock_i  in  1  end of debug session; revoke grant
- unlock_o  out  1  registered debug unlock grant to csr_regfile
- locked_out_o  out  1  lockout active
- fail_cnt_o  out  $clog2(MAX_ATTEMPTS+1)  consecutive failure count

Behaviour:
- Reset: state IDLE, word_cnt=0, mismatch=0, fail_cnt=0, timer=0.
- Reset values: unlock_o=0, resp_valid_o=0, resp_ok_o=0, locked_out_o=0, fail_cnt_o=0. req_ready_o=0 while rst_i is high.
- Reset mid-operation discards any partial attempt and revokes the grant on the next edge.
- req_ready_o=1 only in IDLE and COLLECT. A word is taken on req_valid_i & req_ready_o.
- Each accepted word: mismatch <= mismatch | (req_data_i != key_i[word_cnt*32 +: 32]).
  - No early exit: every word is always consumed. Latency does not depend on the data.
- IDLE: word accepted -> COLLECT with word_cnt=1. If KEY_WORDS==1, go straight to RESPOND.
- COLLECT: word accepted with word_cnt==KEY_WORDS-1 -> RESPOND; otherwise word_cnt++.
- RESPOND: resp_valid_o=1, resp_ok_o=~mismatch; both hold stable until resp_ready_i. On handshake:
  - ok: -> UNLOCKED, fail_cnt<=0. unlock_o rises the cycle after the handshake.
  - fail, fail_cnt+1 < MAX_ATTEMPTS: fail_cnt++ -> IDLE.
  - fail, fail_cnt+1 == MAX_ATTEMPTS: fail_cnt++ -> LOCKOUT, timer<=LOCKOUT_CYCLES.
- Every exit from COLLECT/RESPOND clears word_cnt and mismatch.
- abort_i in COLLECT or RESPOND: counts as a failure (same fail/lockout transition), and no response is issued.
  - Simultaneous abort_i with the last word or with the response handshake: abort wins, and the attempt counts as a failure.
  - abort_i in IDLE, UNLOCKED or LOCKOUT is ignored.
- UNLOCKED: unlock_o=1.
  - relock_i -> IDLE; unlock_o=0 the next cycle.
  - Password words are not accepted (req_ready_o=0).
  - relock_i in any other state is ignored.
- LOCKOUT: locked_out_o=1, req_ready_o=0, timer decrements each cycle. At timer==1 -> IDLE with fail_cnt<=0. Dwell is exactly LOCKOUT_CYCLES cycles.
- unlock_o is driven only from the state register. No combinational path from req_data_i, abort_i or the key to unlock_o.
- fail_cnt saturates at MAX_ATTEMPTS and never wraps.
- Timer width is $clog2(LOCKOUT_CYCLES+1).

Decomposition:
- Shared package dbg_auth_pkg: state enum (IDLE, COLLECT, RESPOND, UNLOCKED, LOCKOUT) and AUTH_WORD_W=32.
- One natural sub-module: dbg_auth_lockout_timer (load/decrement/expire counter).
- Comparison and FSM stay in the top module.

Test Plan:
All scenarios use KEY_WORDS=4, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=16, key words 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444.
- Correct password: send the 4 words back-to-back -> resp_valid_o with resp_ok_o=1 on the cycle after word 3; unlock_o=1 the cycle after the handshake; fail_cnt_o=0.
- Wrong word 0 (0xDEADBEEF), rest correct -> all 4 words accepted, resp_ok_o=0, unlock_o stays 0, fail_cnt_o=1; response latency identical to the correct case.
- Three consecutive wrong attempts -> locked_out_o=1 for exactly 16 cycles with req_ready_o=0; then IDLE, fail_cnt_o=0; a correct attempt then unlocks.
- abort_i asserted together with correct word 3 -> no response, unlock_o=0, fail_cnt_o increments by 1.
- Unlocked, pulse relock_i -> unlock_o=0 the next cycle, req_ready_o=1; resp_ready_i held low in RESPOND keeps resp_valid_o/resp_ok_o stable for 5 cycles.
- rst_i asserted in COLLECT after 2 words -> all outputs at reset values the next cycle; a fresh 4-word correct attempt succeeds.

Source files
------------

// File: rtl/dbg_auth_pkg.sv
// Shared types and constants for the debug-authentication responder.
package dbg_auth_pkg;

    // Width of one streamed password word.
    localparam int unsigned AUTH_WORD_W = 32;

    // Responder states.
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StCollect  = 3'd1,
        StRespond  = 3'd2,
        StUnlocked = 3'd3,
        StLockout  = 3'd4
    } auth_state_e;

    // Counter width able to index n items; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbg_auth_lockout_timer.sv
// Lockout dwell counter: loads the full dwell, counts down while enabled and
// flags the final cycle so the owner can leave lockout on the following edge.
module dbg_auth_lockout_timer
    import dbg_auth_pkg::*;
#(
    parameter int unsigned CYCLES = 1024,
    parameter int unsigned WIDTH  = $clog2(CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic expire_o
);

    logic [WIDTH-1:0] count_q;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= WIDTH'(CYCLES);
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    // Last cycle of the dwell.
    assign expire_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/dbg_auth_unlock.sv
// Debug-authentication responder. Collects a multi-word password, compares it
// against the fused key without early exit, reports the result and owns the
// registered unlock grant, the failure counter and the timed lockout.
module dbg_auth_unlock
    import dbg_auth_pkg::*;
#(
    parameter int unsigned KEY_WORDS      = 4,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [KEY_WORDS*AUTH_WORD_W-1:0]      key_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [AUTH_WORD_W-1:0]                req_data_i,
    input  logic                                  abort_i,
    output logic                                  resp_valid_o,
    input  logic                                  resp_ready_i,
    output logic                                  resp_ok_o,
    input  logic                                  relock_i,
    output logic                                  unlock_o,
    output logic                                  locked_out_o,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     fail_cnt_o
);

    localparam int unsigned WordCntW = cnt_width(KEY_WORDS);
    localparam int unsigned FailCntW = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned TimerW   = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [WordCntW-1:0] LastWord = WordCntW'(KEY_WORDS - 1);
    localparam logic [FailCntW-1:0] MaxFails = FailCntW'(MAX_ATTEMPTS);

    auth_state_e          state_q;
    logic [WordCntW-1:0]  word_cnt_q;
    logic                 mismatch_q;
    logic [FailCntW-1:0]  fail_cnt_q;

    // Registered outputs, updated alongside the state.
    logic unlock_q;
    logic resp_valid_q;
    logic resp_ok_q;
    logic locked_out_q;
    logic ready_q;

    logic [AUTH_WORD_W-1:0] key_word;
    logic                   word_fire;
    logic                   word_mis;
    logic                   mismatch_acc;
    logic                   fail_event;
    logic                   last_fail;
    logic                   timer_load;
    logic                   timer_dec;
    logic                   timer_expire;

    // Reference word for the current position; every word is compared in full.
    assign key_word     = key_i[word_cnt_q*AUTH_WORD_W +: AUTH_WORD_W];
    assign word_fire    = req_valid_i & req_ready_o;
    assign word_mis     = (req_data_i != key_word);
    assign mismatch_acc = mismatch_q | word_mis;

    // Abort beats both the last word and the response handshake.
    assign fail_event = ((state_q == StCollect) && abort_i) ||
                        ((state_q == StRespond) && (abort_i || (resp_ready_i && mismatch_q)));

    // This failure is the one that exhausts the attempt budget.
    assign last_fail  = ({1'b0, fail_cnt_q} + 1'b1) >= {1'b0, MaxFails};

    assign timer_load = fail_event & last_fail;
    assign timer_dec  = (state_q == StLockout);

    dbg_auth_lockout_timer #(
        .CYCLES (LOCKOUT_CYCLES),
        .WIDTH  (TimerW)
    ) u_lockout_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (timer_load),
        .dec_i    (timer_dec),
        .expire_o (timer_expire)
    );

    // Authentication FSM with its counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            word_cnt_q   <= '0;
            mismatch_q   <= 1'b0;
            fail_cnt_q   <= '0;
            unlock_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            locked_out_q <= 1'b0;
            ready_q      <= 1'b1;
        end else if (fail_event) begin
            // Failed or aborted attempt: drop the partial state, never grant.
            word_cnt_q   <= '0;
            mismatch_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            if (last_fail) begin
                state_q      <= StLockout;
                fail_cnt_q   <= MaxFails;
                locked_out_q <= 1'b1;
                ready_q      <= 1'b0;
            end else begin
                state_q    <= StIdle;
                fail_cnt_q <= fail_cnt_q + 1'b1;
                ready_q    <= 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (word_fire) begin
                        mismatch_q <= word_mis;
                        if (KEY_WORDS == 1) begin
                            state_q      <= StRespond;
                            word_cnt_q   <= '0;
                            resp_valid_q <= 1'b1;
                            resp_ok_q    <= ~word_mis;
                            ready_q      <= 1'b0;
                        end else begin
                            state_q    <= StCollect;
                            word_cnt_q <= WordCntW'(1);
                        end
                    end
                end
                StCollect: begin
                    if (word_fire) begin
                        mismatch_q <= mismatch_acc;
                        if (word_cnt_q == LastWord) begin
                            state_q      <= StRespond;
                            word_cnt_q   <= '0;
                            resp_valid_q <= 1'b1;
                            resp_ok_q    <= ~mismatch_acc;
                            ready_q      <= 1'b0;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                    end
                end
                StRespond: begin
                    // A mismatching handshake is taken by fail_event above.
                    if (resp_ready_i && !mismatch_q) begin
                        state_q      <= StUnlocked;
                        mismatch_q   <= 1'b0;
                        fail_cnt_q   <= '0;
                        resp_valid_q <= 1'b0;
                        resp_ok_q    <= 1'b0;
                        unlock_q     <= 1'b1;
                    end
                end
                StUnlocked: begin
                    if (relock_i) begin
                        state_q  <= StIdle;
                        unlock_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end
                end
                StLockout: begin
                    if (timer_expire) begin
                        state_q      <= StIdle;
                        fail_cnt_q   <= '0;
                        locked_out_q <= 1'b0;
                        ready_q      <= 1'b1;
                    end
                end
                default: begin
                    // Unused encodings recover to a safe, ungranted state.
                    state_q      <= StIdle;
                    word_cnt_q   <= '0;
                    mismatch_q   <= 1'b0;
                    unlock_q     <= 1'b0;
                    resp_valid_q <= 1'b0;
                    resp_ok_q    <= 1'b0;
                    locked_out_q <= 1'b0;
                    ready_q      <= 1'b1;
                end
            endcase
        end
    end

    // Ready is forced low while reset is held so no word slips in.
    assign req_ready_o  = ready_q & ~rst_i;
    assign resp_valid_o = resp_valid_q;
    assign resp_ok_o    = resp_ok_q;
    assign unlock_o     = unlock_q;
    assign locked_out_o = locked_out_q;
    assign fail_cnt_o   = fail_cnt_q;

endmodule

// File: tb/tb_dbg_auth_unlock.sv
// Bench for dbg_auth_unlock: transaction-level model plus directed scenarios.
module tb_dbg_auth_unlock;

    localparam int KW   = 4;
    localparam int MAXA = 3;
    localparam int LOCK = 16;
    localparam int FW   = $clog2(MAXA + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [KW*32-1:0] key;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_data;
    logic            abort;
    logic            resp_valid;
    logic            resp_ready;
    logic            resp_ok;
    logic            relock;
    logic            unlock;
    logic            locked_out;
    logic [FW-1:0]   fail_cnt;

    logic [31:0] kw [KW];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    dbg_auth_unlock #(
        .KEY_WORDS      (KW),
        .MAX_ATTEMPTS   (MAXA),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .key_i        (key),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_data_i   (req_data),
        .abort_i      (abort),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_ok_o    (resp_ok),
        .relock_i     (relock),
        .unlock_o     (unlock),
        .locked_out_o (locked_out),
        .fail_cnt_o   (fail_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words received so far, pending result, grant, lockout cycles left.
    logic [31:0] got [$];
    bit m_resp;
    bit m_ok;
    bit m_unlock;
    int m_lock;
    int m_fails;

    task automatic m_fail();
        got.delete();
        m_resp = 1'b0;
        m_fails++;
        if (m_fails >= MAXA) m_lock = LOCK;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                got.delete();
                m_resp = 0; m_ok = 0; m_unlock = 0; m_lock = 0; m_fails = 0;
            end else if (m_lock > 0) begin
                m_lock--;
                if (m_lock == 0) m_fails = 0;
            end else if (m_unlock) begin
                if (relock) m_unlock = 0;
            end else if (m_resp) begin
                if (abort) m_fail();
                else if (resp_ready) begin
                    if (m_ok) begin
                        m_resp = 0; m_unlock = 1; m_fails = 0;
                    end else begin
                        m_fail();
                    end
                end
            end else if (abort && got.size() != 0) begin
                m_fail();
            end else if (req_valid) begin
                got.push_back(req_data);
                if (got.size() == KW) begin
                    m_ok = 1;
                    foreach (got[i]) if (got[i] != kw[i]) m_ok = 0;
                    m_resp = 1;
                    got.delete();
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("m_ready", 32'(req_ready),
                      32'(!rst && !m_resp && !m_unlock && m_lock == 0));
                check("m_resp_valid", 32'(resp_valid), 32'(m_resp));
                if (m_resp) check("m_resp_ok", 32'(resp_ok), 32'(m_ok));
                check("m_unlock", 32'(unlock), 32'(m_unlock));
                check("m_locked_out", 32'(locked_out), 32'(m_lock > 0));
                check("m_fail_cnt", 32'(fail_cnt), 32'(m_fails));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                        input logic [31:0] w3, input bit abort_last);
        logic [31:0] w [4];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_data  = w[i];
            abort     = abort_last && (i == 3);
            cyc();
        end
        req_valid = 1'b0;
        req_data  = '0;
        abort     = 1'b0;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
    endtask

    task automatic do_relock();
        relock = 1'b1;
        cyc();
        relock = 1'b0;
    endtask

    initial begin
        int n;
        kw = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        key = {kw[3], kw[2], kw[1], kw[0]};
        rst = 1'b1; req_valid = 0; req_data = '0; abort = 0; resp_ready = 0; relock = 0;
        cyc();
        cyc();
        chk_en = 1'b1;

        // Reset values
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_unlock", 32'(unlock), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_ok", 32'(resp_ok), 32'd0);
        check("rst_locked", 32'(locked_out), 32'd0);
        check("rst_fails", 32'(fail_cnt), 32'd0);
        rst = 1'b0;
        cyc();
        check("idle_ready", 32'(req_ready), 32'd1);

        // Correct password
        send(kw[0], kw[1], kw[2], kw[3], 1'b0);
        check("ok_latency", 32'(resp_valid), 32'd1);
        check("ok_resp", 32'(resp_ok), 32'd1);
        check("ok_unlock_pre", 32'(unlock), 32'd0);
        handshake();
        check("ok_unlock", 32'(unlock), 32'd1);
        check("ok_fails", 32'(fail_cnt), 32'd0);
        check("unlocked_ready", 32'(req_ready), 32'd0);
        do_relock();
        check("relock_unlock", 32'(unlock), 32'd0);
        check("relock_ready", 32'(req_ready), 32'd1);

        // Three wrong attempts lead to lockout
        for (int a = 1; a <= 3; a++) begin
            send(32'hDEADBEEF, kw[1], kw[2], kw[3], 1'b0);
            check("bad_latency", 32'(resp_valid), 32'd1);
            check("bad_resp", 32'(resp_ok), 32'd0);
            handshake();
            check("bad_unlock", 32'(unlock), 32'd0);
            check("bad_fails", 32'(fail_cnt), 32'(a));
        end
        check("lock_entered", 32'(locked_out), 32'd1);
        n = 0;
        while (locked_out === 1'b1 && n < 40) begin
            check("lock_ready", 32'(req_ready), 32'd0);
            n++;
            cyc();
        end
        check("lock_dwell", 32'(n), 32'd16);
        check("post_lock_fails", 32'(fail_cnt), 32'd0);
        check("post_lock_ready", 32'(req_ready), 32'd1);

        // Correct attempt after lockout
        send(kw[0], kw[1], kw[2], kw[3], 1'b0);
        handshake();
        check("post_lock_unlock", 32'(unlock), 32'd1);
        do_relock();

        // One failure, then abort with the last word
        send(32'hDEADBEEF, kw[1], kw[2], kw[3], 1'b0);
        handshake();
        check("fail1", 32'(fail_cnt), 32'd1);
        send(kw[0], kw[1], kw[2], kw[3], 1'b1);
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_unlock", 32'(unlock), 32'd0);
        check("abort_fails", 32'(fail_cnt), 32'd2);

        // Response held while resp_ready stays low
        send(kw[0], kw[1], kw[2], kw[3], 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_ok", 32'(resp_ok), 32'd1);
            cyc();
        end
        handshake();
        check("stall_unlock", 32'(unlock), 32'd1);
        check("stall_fails", 32'(fail_cnt), 32'd0);
        do_relock();

        // Reset in the middle of collection
        req_valid = 1'b1; req_data = kw[0]; cyc();
        req_data = kw[1]; cyc();
        req_valid = 1'b0; req_data = '0;
        rst = 1'b1;
        cyc();
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_unlock", 32'(unlock), 32'd0);
        check("mid_rst_fails", 32'(fail_cnt), 32'd0);
        rst = 1'b0;
        cyc();
        send(kw[0], kw[1], kw[2], kw[3], 1'b0);
        check("fresh_resp", 32'(resp_ok), 32'd1);
        handshake();
        check("fresh_unlock", 32'(unlock), 32'd1);
        do_relock();

        // Abort together with the response handshake
        send(kw[0], kw[1], kw[2], kw[3], 1'b0);
        abort = 1'b1; resp_ready = 1'b1;
        cyc();
        abort = 1'b0; resp_ready = 1'b0;
        check("rsp_abort_valid", 32'(resp_valid), 32'd0);
        check("rsp_abort_unlock", 32'(unlock), 32'd0);
        check("rsp_abort_fails", 32'(fail_cnt), 32'd1);
        cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
